// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the memory-access stage (master) and the
// data memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_wen             : 1 = store, 0 = load
//   req_size            : 0 byte, 1 half, 2 word, 3 reserved
//   req_addr/req_wdata  : byte address, right-justified store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : right-justified load data, error flag
interface data_mem_responder_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_wen;
  logic [1:0]       req_size;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: services one load/store at a time from an internal
// word array and returns a completion after LATENCY cycles.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of data_mem_responder_if (request/response channels)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a request (req_ready=1 once out of reset)
// ST_WAIT   | access done, counting down the remaining latency
// ST_RESP   | rsp_valid=1, holding rdata/err until rsp_ready
module data_mem_responder #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 1024,
  parameter int unsigned      LATENCY   = 1,
  parameter logic [WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
  input logic                  clk,
  input logic                  rst_n,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned      NB      = WIDTH / 8;
  localparam int unsigned      IDX_W   = $clog2(DEPTH);
  localparam logic [WIDTH:0]   W_RANGE = (WIDTH+1)'(DEPTH * 4);
  localparam logic [3:0]       W_CNT0  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic             r_req_ready;
  logic [WIDTH-1:0] r_rdata;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic             w_accept;
  logic [WIDTH-1:0] w_off;
  logic [1:0]       w_lane;
  logic [IDX_W-1:0] w_idx;
  logic             w_below;
  logic             w_above;
  logic             w_misal;
  logic             w_rsvd;
  logic             w_err;
  logic [NB-1:0]    w_be;
  logic [WIDTH-1:0] w_wdata_sh;
  logic [WIDTH-1:0] w_rd_sh;
  logic [WIDTH-1:0] w_rd_data;

  assign w_accept = bus.req_valid & r_req_ready;

  // Address decode and error classification
  assign w_off   = bus.req_addr - BASE_ADDR;
  assign w_lane  = bus.req_addr[1:0];
  assign w_idx   = w_off[IDX_W+1:2];
  assign w_below = bus.req_addr < BASE_ADDR;
  assign w_above = {1'b0, w_off} >= W_RANGE;
  assign w_misal = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'b00));
  assign w_rsvd  = bus.req_size == 2'd3;
  assign w_err   = w_below | w_above | w_misal | w_rsvd;

  // Store lane enables and data aligned to the addressed lane
  always_comb begin
    w_be = '0;
    case (bus.req_size)
      2'd0:    w_be = NB'(1) << w_lane;
      2'd1:    w_be = NB'(3) << w_lane;
      default: w_be = '1;
    endcase
  end

  assign w_wdata_sh = bus.req_wdata << {w_lane, 3'b000};

  // Load: shift addressed lane down, then keep only the requested size
  assign w_rd_sh = r_mem[w_idx] >> {w_lane, 3'b000};

  always_comb begin
    w_rd_data = w_rd_sh;
    case (bus.req_size)
      2'd0:    w_rd_data = {{(WIDTH-8){1'b0}},  w_rd_sh[7:0]};
      2'd1:    w_rd_data = {{(WIDTH-16){1'b0}}, w_rd_sh[15:0]};
      default: w_rd_data = w_rd_sh;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // registered so req_ready stays low for the first cycle after reset
      r_req_ready <= (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_cnt   <= W_CNT0;
        r_err   <= w_err;
        r_rdata <= (w_err || bus.req_wen) ? '0 : w_rd_data;
      end else if (r_state == ST_WAIT) begin
        if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      end else if ((r_state == ST_RESP) && bus.rsp_ready) begin
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Array has no reset; a store commits on its accept edge
  always_ff @(posedge clk) begin
    if (w_accept && bus.req_wen && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  localparam logic [31:0] B = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_mem_responder_if #(.WIDTH(32)) if1 ();
  data_mem_responder_if #(.WIDTH(32)) if3 ();

  data_mem_responder #(.WIDTH(32), .DEPTH(16), .LATENCY(1), .BASE_ADDR(B)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );
  data_mem_responder #(.WIDTH(32), .DEPTH(16), .LATENCY(3), .BASE_ADDR(B)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // LATENCY=1 transaction with rsp_ready held high
  task automatic req1(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input string tag);
    int n;
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_wen = wen; if1.req_size = size;
    if1.req_addr = addr; if1.req_wdata = wdata; if1.rsp_ready = 1'b1;
    n = 0;
    while (if1.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check(32'(if1.req_ready), 32'd1, {tag, " ready"});
    @(posedge clk); #1;
    if1.req_valid = 1'b0; if1.req_addr = 32'h0; if1.req_wdata = 32'hFFFF_FFFF;
    check(32'(if1.rsp_valid), 32'd1, {tag, " rsp_valid"});
    check(if1.rsp_rdata, exp_rd, {tag, " rdata"});
    check(32'(if1.rsp_err), 32'(exp_err), {tag, " err"});
    @(posedge clk); #1;
    check(32'(if1.rsp_valid), 32'd0, {tag, " valid after hs"});
    check(32'(if1.req_ready), 32'd1, {tag, " ready after hs"});
    check(if1.rsp_rdata, 32'd0, {tag, " rdata after hs"});
    if1.rsp_ready = 1'b0;
  endtask

  // LATENCY=3 transaction, rsp_ready held low for 'hold' cycles of rsp_valid
  task automatic req3(input logic wen, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input int hold, input string tag);
    int n;
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_wen = wen; if3.req_size = size;
    if3.req_addr = addr; if3.req_wdata = wdata; if3.rsp_ready = 1'b0;
    n = 0;
    while (if3.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check(32'(if3.req_ready), 32'd1, {tag, " ready"});
    @(posedge clk); #1;
    if3.req_valid = 1'b0; if3.req_addr = 32'h0; if3.req_wen = ~wen;
    for (int i = 0; i < 3; i++) begin
      check(32'(if3.rsp_valid), (i == 2) ? 32'd0 : 32'd0, {tag, " early valid"});
      check(32'(if3.req_ready), 32'd0, {tag, " ready busy"});
      @(posedge clk); #1;
    end
    check(32'(if3.rsp_valid), 32'd1, {tag, " rsp_valid"});
    check(if3.rsp_rdata, exp_rd, {tag, " rdata"});
    check(32'(if3.rsp_err), 32'(exp_err), {tag, " err"});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check(32'(if3.rsp_valid), 32'd1, {tag, " valid held"});
      check(if3.rsp_rdata, exp_rd, {tag, " rdata held"});
      check(32'(if3.req_ready), 32'd0, {tag, " ready held"});
    end
    @(negedge clk);
    if3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check(32'(if3.rsp_valid), 32'd0, {tag, " valid after hs"});
    check(32'(if3.req_ready), 32'd1, {tag, " ready after hs"});
    check(if3.rsp_rdata, 32'd0, {tag, " rdata after hs"});
    if3.rsp_ready = 1'b0;
  endtask

  initial begin
    if1.req_valid = 1'b0; if1.req_wen = 1'b0; if1.req_size = 2'd0;
    if1.req_addr = '0; if1.req_wdata = '0; if1.rsp_ready = 1'b0;
    if3.req_valid = 1'b0; if3.req_wen = 1'b0; if3.req_size = 2'd0;
    if3.req_addr = '0; if3.req_wdata = '0; if3.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check(32'(if1.req_ready), 32'd0, "reset req_ready");
    check(32'(if1.rsp_valid), 32'd0, "reset rsp_valid");
    check(if1.rsp_rdata, 32'd0, "reset rsp_rdata");
    check(32'(if1.rsp_err), 32'd0, "reset rsp_err");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check(32'(if1.req_ready), 32'd0, "ready before first edge");
    @(posedge clk); #1;
    check(32'(if1.req_ready), 32'd1, "ready after first edge");

    // word store/load, then byte merge
    req1(1'b1, 2'd2, B + 8,  32'hDEAD_BEEF, 32'h0,         1'b0, "st word +8");
    req1(1'b0, 2'd2, B + 8,  32'h0,         32'hDEAD_BEEF, 1'b0, "ld word +8");
    req1(1'b1, 2'd0, B + 11, 32'h0000_00A5, 32'h0,         1'b0, "st byte +11");
    req1(1'b0, 2'd2, B + 8,  32'h0,         32'hA5AD_BEEF, 1'b0, "ld word merged");
    req1(1'b0, 2'd0, B + 11, 32'h0,         32'h0000_00A5, 1'b0, "ld byte +11");
    req1(1'b0, 2'd1, B + 10, 32'h0,         32'h0000_A5AD, 1'b0, "ld half +10");
    req1(1'b1, 2'd1, B + 8,  32'hFFFF_1234, 32'h0,         1'b0, "st half +8");
    req1(1'b0, 2'd2, B + 8,  32'h0,         32'hA5AD_1234, 1'b0, "ld word half-merged");

    // misaligned and reserved accesses leave the array untouched
    req1(1'b1, 2'd2, B + 0,  32'h1122_3344, 32'h0,         1'b0, "st word +0");
    req1(1'b0, 2'd1, B + 1,  32'h0,         32'h0,         1'b1, "ld half misaligned");
    req1(1'b1, 2'd2, B + 2,  32'hFFFF_FFFF, 32'h0,         1'b1, "st word misaligned");
    req1(1'b1, 2'd3, B + 0,  32'hFFFF_FFFF, 32'h0,         1'b1, "st reserved size");
    req1(1'b0, 2'd2, B + 0,  32'h0,         32'h1122_3344, 1'b0, "ld word unchanged");

    // range boundaries (DEPTH=16 -> 64 bytes)
    req1(1'b1, 2'd2, B + 60, 32'hCAFE_F00D, 32'h0,         1'b0, "st last word");
    req1(1'b0, 2'd2, B + 60, 32'h0,         32'hCAFE_F00D, 1'b0, "ld last word");
    req1(1'b0, 2'd2, B + 64, 32'h0,         32'h0,         1'b1, "ld past end");
    req1(1'b0, 2'd2, B - 4,  32'h0,         32'h0,         1'b1, "ld below base");
    req1(1'b1, 2'd0, B + 64, 32'h0000_0077, 32'h0,         1'b1, "st byte past end");

    // LATENCY=3 with backpressure on the response
    req3(1'b1, 2'd2, B + 4, 32'h0BAD_F00D, 32'h0,         1'b0, 0, "L3 st word");
    req3(1'b0, 2'd2, B + 4, 32'h0,         32'h0BAD_F00D, 1'b0, 5, "L3 ld word");
    req3(1'b0, 2'd0, B + 6, 32'h0,         32'h0000_00AD, 1'b0, 1, "L3 ld byte");

    // reset while a store is in WAIT
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_wen = 1'b1; if3.req_size = 2'd2;
    if3.req_addr = B + 20; if3.req_wdata = 32'h1234_5678; if3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    check(32'(if3.req_ready), 32'd0, "rst-test busy");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check(32'(if3.req_ready), 32'd0, "async rst req_ready");
    check(32'(if3.rsp_valid), 32'd0, "async rst rsp_valid");
    check(if3.rsp_rdata, 32'd0, "async rst rsp_rdata");
    check(32'(if3.rsp_err), 32'd0, "async rst rsp_err");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check(32'(if3.rsp_valid), 32'd0, "no rsp during reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    if3.rsp_ready = 1'b0;
    @(posedge clk); #1;
    check(32'(if3.rsp_valid), 32'd0, "pending rsp discarded");
    req3(1'b0, 2'd2, B + 20, 32'h0, 32'h1234_5678, 1'b0, 0, "ld after reset");
    req1(1'b0, 2'd2, B + 8,  32'h0, 32'hA5AD_1234, 1'b0, "L1 mem kept over reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
